fft_stage_scheduler: RTL and testbench

Sequences a single radix-2 butterfly through all LOG2_N stages of an in-place N-point DIF FFT. On `start` it walks every stage and issues N/2 butterfly operations per stage. Each operation carries the A/B memory addresses, the twiddle ROM index and a 2-bit control tag, driven into the butterfly's iact/ictrl/input_memory_address inputs. Completions arrive on the butterfly's oact; the scheduler limits in-flight operations and drains each stage before starting the next, which avoids in-place read-after-write hazards.

---
 rtl/fft_stage_scheduler.sv | 172 +++++++++++++++++
 tb/tb_fft_stage_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_scheduler.sv
// fft_stage_scheduler: walks a radix-2 DIF FFT stage by stage, issuing
// butterflies with a bounded in-flight count and draining between stages.
module fft_stage_scheduler #(
  parameter int LOG2_N          = 9,
  parameter int MAX_OUTSTANDING = 8,
  parameter int STAGE_W         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [STAGE_W-1:0] stage,
  output logic               bf_iact,
  output logic [1:0]         bf_ictrl,
  output logic [LOG2_N-1:0]  addr_a,
  output logic [LOG2_N-1:0]  addr_b,
  output logic [LOG2_N-2:0]  tw_addr,
  input  logic               bf_oact,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [LOG2_N-2:0]  K_LAST  = '1;
  localparam logic [LOG2_N-2:0]  K_ONE   = (LOG2_N-1)'(1);
  localparam logic [LOG2_N-1:0]  A_ONE   = LOG2_N'(1);
  localparam logic [STAGE_W-1:0] S_LAST  = STAGE_W'(LOG2_N-1);
  localparam logic [STAGE_W-1:0] S_ONE   = STAGE_W'(1);
  localparam logic [3:0]         OUT_MAX = 4'(MAX_OUTSTANDING);

  state_t             state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [LOG2_N-2:0]  k_q, k_d;
  logic [3:0]         out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               iact_q, iact_d;
  logic               err_q, err_d;
  logic [1:0]         ictrl_q, ictrl_d;
  logic [LOG2_N-1:0]  a_q, a_d;
  logic [LOG2_N-1:0]  b_q, b_d;
  logic [LOG2_N-2:0]  tw_q, tw_d;

  logic [LOG2_N-2:0]  mask;
  logic [LOG2_N-2:0]  j;
  logic [LOG2_N-1:0]  span;
  logic [LOG2_N-1:0]  a_nxt;
  logic [LOG2_N-1:0]  b_nxt;
  logic [LOG2_N-2:0]  tw_nxt;
  logic               active;
  logic               issue;
  logic               dec;

  // mask = span-1; at stage 0 the shift overflows and wraps to all ones
  always_comb begin
    mask   = (K_ONE << (S_LAST - stage_q)) - K_ONE;
    j      = k_q & mask;
    span   = {1'b0, mask} + A_ONE;
    a_nxt  = {k_q & ~mask, 1'b0} | {1'b0, j};
    b_nxt  = a_nxt + span;
    tw_nxt = j << stage_q;
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    iact_d  = 1'b0;
    err_d   = err_q;
    ictrl_d = ictrl_q;
    a_d     = a_q;
    b_d     = b_q;
    tw_d    = tw_q;
    active  = (state_q == RUN) || (state_q == DRAIN);
    issue   = (state_q == RUN) && (out_q < OUT_MAX);
    dec     = active && bf_oact && (out_q != 4'd0);
    if (active && bf_oact && (out_q == 4'd0)) begin
      err_d = 1'b1;
    end
    out_d = out_q + {3'b000, issue} - {3'b000, dec};
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          stage_d = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (issue) begin
          iact_d  = 1'b1;
          a_d     = a_nxt;
          b_d     = b_nxt;
          tw_d    = tw_nxt;
          ictrl_d = {stage_q == S_LAST, stage_q[0]};
          k_d     = k_q + K_ONE;
          if (k_q == K_LAST) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_d == 4'd0) begin
          if (stage_q == S_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            stage_d = stage_q + S_ONE;
            k_d     = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      k_q     <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      iact_q  <= 1'b0;
      err_q   <= 1'b0;
      ictrl_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      iact_q  <= iact_d;
      err_q   <= err_d;
      ictrl_q <= ictrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tw_q    <= tw_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign stage    = stage_q;
  assign bf_iact  = iact_q;
  assign bf_ictrl = ictrl_q;
  assign addr_a   = a_q;
  assign addr_b   = b_q;
  assign tw_addr  = tw_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// tb_fft_stage_scheduler: directed checks on two N=8 schedulers
// (MAX=8 and MAX=2) driven by a queued butterfly latency model.
module tb_fft_stage_scheduler;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] start = '0;
  logic [1:0] oact  = '0;
  logic [1:0] busy;
  logic [1:0] done;
  logic [1:0] iact;
  logic [1:0] err;
  logic [3:0] stage [2];
  logic [1:0] ictrl [2];
  logic [2:0] aa    [2];
  logic [2:0] ab    [2];
  logic [1:0] tw    [2];

  int nchk      = 0;
  int nfail     = 0;
  int cyc       = 0;
  int last_gaps = 0;
  int dly      [2]  = '{3, 5};
  int hold_idx [2]  = '{0, 0};
  int push_cnt [2]  = '{0, 0};
  int pend     [2]  = '{0, 0};
  int maxpend  [2]  = '{0, 0};
  int fq       [2][$];
  int exp_a    [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int exp_tw   [12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
  int span_of  [3]  = '{4, 2, 1};

  always #5 clk = ~clk;

  fft_stage_scheduler #(
    .LOG2_N(3), .MAX_OUTSTANDING(8), .STAGE_W(4)
  ) u_fast (
    .clk(clk), .reset(reset), .start(start[0]),
    .busy(busy[0]), .done(done[0]), .stage(stage[0]),
    .bf_iact(iact[0]), .bf_ictrl(ictrl[0]),
    .addr_a(aa[0]), .addr_b(ab[0]), .tw_addr(tw[0]),
    .bf_oact(oact[0]), .err(err[0])
  );

  fft_stage_scheduler #(
    .LOG2_N(3), .MAX_OUTSTANDING(2), .STAGE_W(4)
  ) u_slow (
    .clk(clk), .reset(reset), .start(start[1]),
    .busy(busy[1]), .done(done[1]), .stage(stage[1]),
    .bf_iact(iact[1]), .bf_ictrl(ictrl[1]),
    .addr_a(aa[1]), .addr_b(ab[1]), .tw_addr(tw[1]),
    .bf_oact(oact[1]), .err(err[1])
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock: outputs sampled 1ns after the edge, then the butterfly
  // model schedules completions and drives oact for the next edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (oact[i] && pend[i] > 0) pend[i]--;
      oact[i] = 1'b0;
      if (iact[i]) begin
        push_cnt[i]++;
        fq[i].push_back(cyc + dly[i] +
          ((push_cnt[i] == hold_idx[i]) ? 10 : 0));
        pend[i]++;
        if (pend[i] > maxpend[i]) maxpend[i] = pend[i];
      end
      if (fq[i].size() > 0 && fq[i][0] <= cyc) begin
        void'(fq[i].pop_front());
        oact[i] = 1'b1;
      end
    end
  endtask

  task automatic chk_zero(int i, string tag);
    chk({tag, "_busy"}, busy[i], 0);
    chk({tag, "_done"}, done[i], 0);
    chk({tag, "_iact"}, iact[i], 0);
    chk({tag, "_err"}, err[i], 0);
    chk({tag, "_stage"}, stage[i], 0);
    chk({tag, "_addr_a"}, aa[i], 0);
    chk({tag, "_addr_b"}, ab[i], 0);
    chk({tag, "_tw"}, tw[i], 0);
    chk({tag, "_ictrl"}, ictrl[i], 0);
  endtask

  task automatic run_fft(int i, int hold, bit keep, bit spur);
    int idx, dn, c4, c5, cs1, gaps;
    idx = 0; dn = 0; c4 = -1; c5 = -1; cs1 = -1; gaps = 0;
    hold_idx[i] = hold;
    push_cnt[i] = 0;
    maxpend[i]  = 0;
    start[i]    = 1'b1;
    step();
    if (!keep) start[i] = 1'b0;
    chk("busy_on_start", busy[i], 1);
    chk("err_clr_on_start", err[i], 0);
    chk("no_iact_at_start", iact[i], 0);
    for (int t = 0; t < 300; t++) begin
      step();
      if (iact[i]) begin
        if (idx < 12) begin
          chk("addr_a", aa[i], exp_a[idx]);
          chk("addr_b", ab[i], exp_a[idx] + span_of[idx / 4]);
          chk("tw_addr", tw[i], exp_tw[idx]);
          chk("stage", stage[i], idx / 4);
          chk("ictrl", ictrl[i], (idx / 4 == 2) ? 2 : idx / 4);
        end
        if (idx == 3) c4 = cyc;
        if (idx == 4) c5 = cyc;
        idx++;
      end else if (idx > 0 && idx % 4 != 0) begin
        gaps++;
      end
      if (cs1 < 0 && stage[i] == 1) begin
        cs1 = cyc;
        if (spur) begin
          chk("err_before_spur", err[i], 0);
          oact[i] = 1'b1;
        end
      end else if (spur && cs1 >= 0 && cyc == cs1 + 1) begin
        chk("err_after_spur", err[i], 1);
      end
      if (done[i]) dn++;
      if (!busy[i]) break;
    end
    chk("busy_end", busy[i], 0);
    chk("done_end", done[i], 0);
    chk("ops_issued", idx, 12);
    chk("done_pulses", dn, 1);
    chk("err_end", err[i], {31'd0, spur});
    if (hold > 0) begin
      chk("stage1_after_held_oact", cs1, c4 + 14);
      chk("first_s1_issue", c5, c4 + 15);
    end
    last_gaps = gaps;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk_zero(0, "rst_fast");
    chk_zero(1, "rst_slow");
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;

    run_fft(0, 0, 1'b0, 1'b0);
    chk("fast_no_gaps", last_gaps, 0);

    run_fft(1, 0, 1'b0, 1'b0);
    chk("slow_max_pending", maxpend[1], 2);
    chk("slow_has_gaps", {31'd0, last_gaps > 0}, 1);

    run_fft(0, 4, 1'b0, 1'b0);

    run_fft(0, 0, 1'b0, 1'b1);
    run_fft(0, 0, 1'b0, 1'b0);

    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (stage[0] == 1 && iact[0]) break;
      step();
    end
    chk("reached_stage1", stage[0], 1);
    #2 reset = 1'b0;
    #1;
    chk_zero(0, "async_rst");
    fq[0].delete();
    pend[0] = 0;
    oact[0] = 1'b0;
    step();
    step();
    #2 reset = 1'b1;
    for (int t = 0; t < 3; t++) begin
      oact[0] = 1'b1;
      step();
    end
    chk("idle_oact_err", err[0], 0);
    chk("idle_oact_busy", busy[0], 0);
    run_fft(0, 0, 1'b0, 1'b0);

    run_fft(0, 0, 1'b1, 1'b0);
    run_fft(0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
